// File: rtl/p4_router_pkg.sv
// Shared types and constants for the P4 router egress demultiplexer.
// Contents:
//   state_e              - egress FSM states (idle, forward, discard)
//   DefaultMetadataWidth - default width of the P4 user metadata word
//   DefaultDropBit       - default metadata bit index of the drop flag
//   DropCountWidth       - width of the dropped-packet counter
//   AxisDataWidth/KeepW  - AXI-Stream tdata / tkeep widths
package p4_router_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StForward = 2'd1,
    StDiscard = 2'd2
  } state_e;

  localparam int unsigned DefaultMetadataWidth = 19;
  localparam int unsigned DefaultDropBit       = 18;
  localparam int unsigned DropCountWidth       = 32;
  localparam int unsigned AxisDataWidth        = 64;
  localparam int unsigned AxisKeepWidth        = 8;

endpackage

// File: rtl/p4_router_meta_fifo.sv
// Synchronous metadata FIFO for the egress demultiplexer.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored. Read data is the head entry (show-ahead).
// Ports:
//   clk, sresetn - clock and synchronous active-low reset (empties the FIFO)
//   push, wdata  - write request and data
//   pop          - consume the head entry
//   rdata        - head entry, valid while empty is low
//   full, empty  - occupancy flags
module p4_router_meta_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/p4_router_egress_demux.sv
// P4 router egress demultiplexer: steers each packet of the input AXI-Stream
// to one of NUM_PORTS egress streams, chosen by the metadata word the P4
// router emits for that packet. Metadata words are queued in order; each
// packet consumes one word when it starts. Packets with the drop flag set or
// an out-of-range port field are drained and discarded.
// Ports:
//   clk, sresetn       - clock and synchronous active-low reset
//   data_in_*          - input AXI-Stream (64-bit tdata, 8-bit tkeep)
//   meta_in[_valid]    - per-packet metadata, one-cycle strobe, no backpressure
//   data_out_*         - egress streams, port p at slice p of each bus
//   drop_count         - saturating count of discarded packets
//   meta_overflow      - sticky, set when a metadata word is lost to a full queue
// Optional feature: define P4_ROUTER_EGRESS_STATS_EN to build drop_count and
// meta_overflow; otherwise both are tied to zero.
module p4_router_egress_demux
  import p4_router_pkg::*;
#(
  parameter int unsigned METADATA_WIDTH  = DefaultMetadataWidth,
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned DROP_BIT        = DefaultDropBit,
  parameter int unsigned META_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               sresetn,
  input  logic [AxisDataWidth-1:0]           data_in_tdata,
  input  logic [AxisKeepWidth-1:0]           data_in_tkeep,
  input  logic                               data_in_tvalid,
  input  logic                               data_in_tlast,
  output logic                               data_in_tready,
  input  logic [METADATA_WIDTH-1:0]          meta_in,
  input  logic                               meta_in_valid,
  output logic [NUM_PORTS*AxisDataWidth-1:0] data_out_tdata,
  output logic [NUM_PORTS*AxisKeepWidth-1:0] data_out_tkeep,
  output logic [NUM_PORTS-1:0]               data_out_tvalid,
  output logic [NUM_PORTS-1:0]               data_out_tlast,
  input  logic [NUM_PORTS-1:0]               data_out_tready,
  output logic [DropCountWidth-1:0]          drop_count,
  output logic                               meta_overflow
);

  localparam int unsigned PortW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
    $error("NUM_PORTS must be in 2..16");
  end
  if (DROP_BIT >= METADATA_WIDTH) begin : g_bad_drop_bit
    $error("DROP_BIT must be below METADATA_WIDTH");
  end
  if (PortW > METADATA_WIDTH) begin : g_bad_meta_width
    $error("METADATA_WIDTH too narrow for the port field");
  end
  if (META_FIFO_DEPTH < 2 || (META_FIFO_DEPTH & (META_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("META_FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_e                    state_q;
  logic [PortW-1:0]          sel_q;
  logic [METADATA_WIDTH-1:0] fifo_rdata;
  logic                      fifo_full, fifo_empty;
  logic                      pop;
  logic [PortW-1:0]          port_field;
  logic                      discard_pkt;
  logic                      in_last_hs;

  assign pop         = (state_q == StIdle) && !fifo_empty && data_in_tvalid;
  assign port_field  = fifo_rdata[PortW-1:0];
  assign discard_pkt = fifo_rdata[DROP_BIT] || (32'(port_field) >= NUM_PORTS);
  assign in_last_hs  = data_in_tvalid && data_in_tready && data_in_tlast;

  p4_router_meta_fifo #(
    .Width (METADATA_WIDTH),
    .Depth (META_FIFO_DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .sresetn (sresetn),
    .push    (meta_in_valid),
    .wdata   (meta_in),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            sel_q   <= port_field;
            state_q <= discard_pkt ? StDiscard : StForward;
          end
        end
        StForward, StDiscard: begin
          if (in_last_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload is broadcast; only the selected port sees tvalid.
  assign data_out_tdata = {NUM_PORTS{data_in_tdata}};
  assign data_out_tkeep = {NUM_PORTS{data_in_tkeep}};
  assign data_out_tlast = {NUM_PORTS{data_in_tlast}};

  // Handshake outputs are gated by sresetn so they are quiet for the whole
  // reset, not only from the first reset edge on.
  always_comb begin
    data_out_tvalid = '0;
    data_in_tready  = 1'b0;
    unique case (state_q)
      StForward: begin
        data_out_tvalid[sel_q] = data_in_tvalid && sresetn;
        data_in_tready         = data_out_tready[sel_q] && sresetn;
      end
      StDiscard: data_in_tready = sresetn;
      default: ;
    endcase
  end

  // Only the port field and drop flag steer the packet.
  logic unused_meta;
  assign unused_meta = ^fifo_rdata;

`ifdef P4_ROUTER_EGRESS_STATS_EN
  logic [DropCountWidth-1:0] drop_count_q;
  logic                      meta_overflow_q;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      drop_count_q    <= '0;
      meta_overflow_q <= 1'b0;
    end else begin
      if (state_q == StDiscard && in_last_hs && drop_count_q != '1) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
      // A word is lost only when the queue is full and nothing leaves it.
      if (meta_in_valid && fifo_full && !pop) meta_overflow_q <= 1'b1;
    end
  end

  assign drop_count    = drop_count_q;
  assign meta_overflow = meta_overflow_q;
`else
  logic unused_full;
  assign unused_full   = fifo_full;
  assign drop_count    = '0;
  assign meta_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_p4_router_egress_demux.sv
module tb_p4_router_egress_demux;

  localparam int NP = 4;
  localparam int MW = 19;
  localparam int DB = 18;
  localparam int QD = 4;
`ifdef P4_ROUTER_EGRESS_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             sresetn;
  logic [63:0]      in_tdata;
  logic [7:0]       in_tkeep;
  logic             in_tvalid, in_tlast, in_tready;
  logic [MW-1:0]    meta_in;
  logic             meta_in_valid;
  logic [NP*64-1:0] out_tdata;
  logic [NP*8-1:0]  out_tkeep;
  logic [NP-1:0]    out_tvalid, out_tlast, out_tready;
  logic [31:0]      drop_count;
  logic             meta_overflow;

  // Second instance with a non-power-of-2 port count to reach a bad port field.
  logic [63:0]      d3_tdata;
  logic [7:0]       d3_tkeep;
  logic             d3_tvalid, d3_tlast, d3_tready;
  logic [MW-1:0]    d3_meta;
  logic             d3_meta_valid;
  logic [3*64-1:0]  d3_out_tdata;
  logic [3*8-1:0]   d3_out_tkeep;
  logic [2:0]       d3_out_tvalid, d3_out_tlast, d3_out_tready;
  logic [31:0]      d3_drop;
  logic             d3_ovf;

  always #5 clk = ~clk;

  p4_router_egress_demux #(
    .METADATA_WIDTH (MW), .NUM_PORTS (NP), .DROP_BIT (DB), .META_FIFO_DEPTH (QD)
  ) dut (
    .clk (clk), .sresetn (sresetn),
    .data_in_tdata (in_tdata), .data_in_tkeep (in_tkeep), .data_in_tvalid (in_tvalid),
    .data_in_tlast (in_tlast), .data_in_tready (in_tready),
    .meta_in (meta_in), .meta_in_valid (meta_in_valid),
    .data_out_tdata (out_tdata), .data_out_tkeep (out_tkeep), .data_out_tvalid (out_tvalid),
    .data_out_tlast (out_tlast), .data_out_tready (out_tready),
    .drop_count (drop_count), .meta_overflow (meta_overflow)
  );

  p4_router_egress_demux #(
    .METADATA_WIDTH (MW), .NUM_PORTS (3), .DROP_BIT (DB), .META_FIFO_DEPTH (QD)
  ) dut3 (
    .clk (clk), .sresetn (sresetn),
    .data_in_tdata (d3_tdata), .data_in_tkeep (d3_tkeep), .data_in_tvalid (d3_tvalid),
    .data_in_tlast (d3_tlast), .data_in_tready (d3_tready),
    .meta_in (d3_meta), .meta_in_valid (d3_meta_valid),
    .data_out_tdata (d3_out_tdata), .data_out_tkeep (d3_out_tkeep),
    .data_out_tvalid (d3_out_tvalid), .data_out_tlast (d3_out_tlast),
    .data_out_tready (d3_out_tready),
    .drop_count (d3_drop), .meta_overflow (d3_ovf)
  );

  int checks = 0;
  int errors = 0;
  int multi_valid = 0;
  bit rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  logic [MW-1:0] model_q[$];
  bit            model_ovf;
  int            model_drops;

  // Destination from the routing rule; -1 means the packet is discarded.
  function automatic int route(input logic [MW-1:0] m);
    int port;
    port = int'(m) % (1 << $clog2(NP));
    if (m[DB] || port >= NP) return -1;
    return port;
  endfunction

  function automatic void model_reset();
    model_q.delete();
    model_ovf   = 1'b0;
    model_drops = 0;
  endfunction

  // ---------------- transmit / receive records ----------------
  logic [63:0] tx_data[$];
  logic [7:0]  tx_keep[$];
  logic        tx_last[$];
  int          rx_port[$];
  logic [63:0] rx_data[$];
  logic [7:0]  rx_keep[$];
  logic        rx_last[$];

  always @(negedge clk) begin
    if ($countones(out_tvalid) > 1) multi_valid++;
    for (int p = 0; p < NP; p++) begin
      if (out_tvalid[p] && out_tready[p]) begin
        rx_port.push_back(p);
        rx_data.push_back(out_tdata[p*64 +: 64]);
        rx_keep.push_back(out_tkeep[p*8 +: 8]);
        rx_last.push_back(out_tlast[p]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = rdy_rand ? NP'($urandom) : '1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_meta(input logic [MW-1:0] m);
    meta_in       = m;
    meta_in_valid = 1'b1;
    if (model_q.size() < QD) model_q.push_back(m);
    else model_ovf = 1'b1;
    tick();
    meta_in_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] seed, input int b, input bit last);
    logic [63:0] d;
    logic [7:0]  k;
    d = {seed, 32'(b)};
    k = 8'($urandom);
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = last;
    in_tvalid = 1'b1;
    tx_data.push_back(d);
    tx_keep.push_back(k);
    tx_last.push_back(last);
  endtask

  // Waits for the current beat to be accepted; returns cycles spent stalled.
  task automatic wait_hs(output int stalls);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (in_tready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL hs_timeout: got %0d stall cycles required at most 200", stalls);
        break;
      end
    end
    tick();
  endtask

  task automatic send_packet(input int nbeats, output int stall_first);
    logic [31:0] seed;
    int st;
    seed = $urandom;
    stall_first = 0;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(seed, b, b == nbeats - 1);
      wait_hs(st);
      if (b == 0) stall_first = st;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic clear_records();
    tx_data.delete(); tx_keep.delete(); tx_last.delete();
    rx_port.delete(); rx_data.delete(); rx_keep.delete(); rx_last.delete();
  endtask

  task automatic check_pkt(input string name, input int exp_port);
    int bad;
    int exp_n;
    bad   = 0;
    exp_n = (exp_port < 0) ? 0 : tx_data.size();
    chk({name, "_beats"}, 64'(rx_data.size()), 64'(exp_n));
    if (exp_port >= 0) begin
      if (rx_data.size() == tx_data.size()) begin
        for (int i = 0; i < rx_data.size(); i++) begin
          if (rx_port[i] != exp_port || rx_data[i] !== tx_data[i] ||
              rx_keep[i] !== tx_keep[i] || rx_last[i] !== tx_last[i]) bad++;
        end
      end
      chk({name, "_content"}, 64'(bad), 64'd0);
    end
    clear_records();
  endtask

  task automatic check_stats(input string name);
    chk({name, "_drop_count"}, 64'(drop_count), StatsEn ? 64'(model_drops) : 64'd0);
    chk({name, "_overflow"}, 64'(meta_overflow), StatsEn ? 64'(model_ovf) : 64'd0);
  endtask

  // Consumes the head of the model queue for a packet already announced.
  task automatic run_queued(input string name, input int nbeats);
    logic [MW-1:0] m;
    int exp, st;
    m   = model_q.pop_front();
    exp = route(m);
    send_packet(nbeats, st);
    if (exp < 0) model_drops++;
    check_pkt(name, exp);
    check_stats(name);
  endtask

  // Offers a packet with the queue empty, checks it is held, then releases it.
  task automatic stall_then_release(input string name, input logic [MW-1:0] m);
    int hi, st, exp;
    hi = 0;
    drive_beat($urandom, 0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      if (in_tready || (|out_tvalid)) hi++;
    end
    chk({name, "_held"}, 64'(hi), 64'd0);
    tick();
    pulse_meta(m);
    exp = route(model_q.pop_front());
    wait_hs(st);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    if (exp < 0) model_drops++;
    check_pkt(name, exp);
  endtask

  task automatic d3_pkt(input string name, input logic [MW-1:0] m, input logic [2:0] exp_v,
                        input int exp_drops);
    int n;
    n = 0;
    d3_meta       = m;
    d3_meta_valid = 1'b1;
    tick();
    d3_meta_valid = 1'b0;
    d3_tdata  = 64'hA5A5;
    d3_tkeep  = 8'hFF;
    d3_tvalid = 1'b1;
    d3_tlast  = 1'b1;
    forever begin
      @(negedge clk);
      if (d3_tready) break;
      n++;
      if (n > 20) break;
    end
    chk({name, "_stall"}, 64'(n), 64'd1);
    chk({name, "_tvalid"}, 64'(d3_out_tvalid), 64'(exp_v));
    tick();
    d3_tvalid = 1'b0;
    chk({name, "_drop_count"}, 64'(d3_drop), StatsEn ? 64'(exp_drops) : 64'd0);
  endtask

  typedef struct {
    logic [MW-1:0] meta;
    int            beats;
    bit            rnd;
    int            exp_port;
  } vec_t;

  vec_t vec[$];

  initial begin
    int st;
    logic [MW-1:0] first;

    sresetn = 1'b0;
    in_tdata = '0; in_tkeep = '0; in_tvalid = 1'b0; in_tlast = 1'b0;
    meta_in = '0; meta_in_valid = 1'b0; out_tready = '1;
    d3_tdata = '0; d3_tkeep = '0; d3_tvalid = 1'b0; d3_tlast = 1'b0;
    d3_meta = '0; d3_meta_valid = 1'b0; d3_out_tready = '1;
    model_reset();

    vec.push_back('{19'h00002,  3, 1'b0,  2});
    vec.push_back('{19'h40000,  5, 1'b0, -1});
    vec.push_back('{19'h00001,  1, 1'b0,  1});
    vec.push_back('{19'h00003,  2, 1'b0,  3});
    vec.push_back('{19'h3FFFC,  4, 1'b0,  0});
    vec.push_back('{19'h40003,  1, 1'b0, -1});
    vec.push_back('{19'h00001, 10, 1'b1,  1});
    vec.push_back('{19'h00000,  1, 1'b0,  0});

    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tready", 64'(in_tready), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_overflow", 64'(meta_overflow), 64'd0);
    tick();
    sresetn = 1'b1;
    tick();

    // Directed vectors.
    for (int i = 0; i < vec.size(); i++) begin
      int exp_before;
      rdy_rand = vec[i].rnd;
      exp_before = model_drops;
      pulse_meta(vec[i].meta);
      void'(model_q.pop_front());
      chk($sformatf("vec%0d_drops_before", i), 64'(drop_count),
          StatsEn ? 64'(exp_before) : 64'd0);
      send_packet(vec[i].beats, st);
      rdy_rand = 1'b0;
      if (vec[i].exp_port < 0) model_drops++;
      if (!vec[i].rnd) chk($sformatf("vec%0d_stall", i), 64'(st), 64'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_gap", i), 64'(in_tready), 64'd0);
      tick();
      check_pkt($sformatf("vec%0d", i), vec[i].exp_port);
      check_stats($sformatf("vec%0d", i));
    end

    // Full queue: a new word arriving in the same cycle as a pop is kept.
    pulse_meta(19'h1); pulse_meta(19'h2); pulse_meta(19'h3); pulse_meta(19'h0);
    check_stats("fill");
    meta_in       = 19'h2;
    meta_in_valid = 1'b1;
    drive_beat($urandom, 0, 1'b1);
    first = model_q.pop_front();
    model_q.push_back(19'h2);
    tick();
    meta_in_valid = 1'b0;
    wait_hs(st);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    check_pkt("copop", route(first));
    check_stats("copop");
    for (int k = 0; k < 4; k++) run_queued($sformatf("copop_drain%0d", k), 1 + k);

    // Overflow: the fifth word is lost, the first four still route.
    pulse_meta(19'h1); pulse_meta(19'h2); pulse_meta(19'h3); pulse_meta(19'h0);
    check_stats("ovf_before");
    pulse_meta(19'h3);
    check_stats("ovf_set");
    for (int k = 0; k < 4; k++) run_queued($sformatf("ovf_drain%0d", k), 1);
    stall_then_release("empty_wait", 19'h3);
    check_stats("empty_wait");

    // Random traffic against the routing rule.
    for (int k = 0; k < 24; k++) begin
      logic [MW-1:0] m;
      m = MW'($urandom) & 19'h3FFFF;
      if ($urandom_range(0, 5) == 0) m[DB] = 1'b1;
      rdy_rand = $urandom_range(0, 1) == 1;
      pulse_meta(m);
      run_queued($sformatf("rand%0d", k), $urandom_range(1, 6));
      rdy_rand = 1'b0;
    end
    tick();

    // Reset in the middle of a packet, with one word still queued.
    pulse_meta(19'h1);
    pulse_meta(19'h3);
    void'(model_q.pop_front());
    drive_beat(32'h600D, 0, 1'b0);
    wait_hs(st);
    drive_beat(32'h600D, 1, 1'b0);
    wait_hs(st);
    drive_beat(32'h600D, 2, 1'b0);
    sresetn = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_tready", 64'(in_tready), 64'd0);
    tick();
    sresetn   = 1'b1;
    in_tvalid = 1'b0;
    model_reset();
    void'(tx_data.pop_back());
    void'(tx_keep.pop_back());
    void'(tx_last.pop_back());
    @(negedge clk);
    chk("postrst_tvalid", 64'(out_tvalid), 64'd0);
    chk("postrst_tready", 64'(in_tready), 64'd0);
    tick();
    check_pkt("midrst_partial", 1);
    check_stats("postrst");
    stall_then_release("postrst_pkt", 19'h0);

    // Port field beyond the port count on a 3-port instance.
    d3_pkt("p3_badport", 19'h00003, 3'b000, 1);
    d3_pkt("p3_port2", 19'h00002, 3'b100, 1);

    chk("single_tvalid", 64'(multi_valid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
